sparse_mac_feeder: RTL and testbench
====================================

// Module: sparse_mac_feeder
// PURPOSE
//  Zero-skipping operand sequencer directly upstream of MAC_UNIT.
//  Accepts a compressed stream of nonzero activations (value + channel index).
//  Looks up 4 filter weights per activation and issues one MAC op per cycle on
//  Mac_act/Mac_weight/Mac_select/Mac_block_control, skipping zero products.
//  Drives Block_control=0 on the first op of each select per window (clears the
//  accumulator) and flushes untouched selects at window end.
// PARAMETERS
//  DATA_WIDTH    8   activation/weight width; must match MAC_UNIT
//  IDX_WIDTH     4   channel index width; weight depth DEPTH = 2**IDX_WIDTH
//  SELECT_WIDTH  2   select width; fixed 4 accumulators (sel 0..3)
// PORTS
//  Clk                in   1           rising-edge clock
//  rst                in   1           synchronous, active-high reset
//  Wt_wr_en           in   1           weight write strobe
//  Wt_wr_sel          in   SELECT_W    target filter 0..3
//  Wt_wr_addr         in   IDX_WIDTH   target channel
//  Wt_wr_data         in   DATA_WIDTH  weight value
//  Act_valid          in   1           activation beat valid
//  Act_ready          out  1           feeder can accept a beat
//  Act_value          in   DATA_WIDTH  activation value
//  Act_index          in   IDX_WIDTH   channel index of activation
//  Act_last           in   1           final beat of window
//  Mac_act            out  DATA_WIDTH  to MAC_UNIT Input_act
//  Mac_weight         out  DATA_WIDTH  to MAC_UNIT Input_weight
//  Mac_select         out  SELECT_W    to MAC_UNIT Select
//  Mac_block_control  out  1           to MAC_UNIT Block_control
//  Window_done        out  1           1-cycle pulse: all window ops issued
// BEHAVIOUR
//  - All outputs registered. Reset (held while rst=1): state IDLE, touched=4'b0,
//    weights all 0, Act_ready=0, Window_done=0, idle op with Mac_select=0.
//  - Idle op: Mac_act=0, Mac_weight=0, Mac_block_control=1, Mac_select held at
//    last value. It adds zero, so accumulators are unchanged.
//  - Handshake: beat accepted when Act_valid&&Act_ready. Act_ready=1 only in IDLE
//    with rst=0.
//  - IDLE: on accept, latch value/last and mask[s]=(W[s][Act_index]!=0).
//    If value==0 or mask==0, issue no ops: next state is FLUSH if last, else IDLE.
//    Otherwise go to ISSUE.
//  - ISSUE: each cycle issue the lowest set mask bit s: Mac_act=value,
//    Mac_weight=W[s][idx], Mac_select=s, Mac_block_control=touched[s].
//    Then set touched[s] and clear mask[s]. When mask is empty, go to FLUSH if
//    last, else IDLE. First op appears the cycle after accept.
//    Latency: k nonzero weights -> k op cycles, Act_ready low for k cycles.
//  - FLUSH: each cycle issue the lowest s with touched[s]=0: act=0, weight=0,
//    select=s, block=0, which writes 0 into that accumulator. Set touched[s].
//    When all touched, go to DONE. FLUSH takes 0 cycles if all selects were
//    already touched (go straight to DONE).
//  - DONE: one cycle, Window_done=1, idle op, clear touched, go to IDLE.
//    MAC sums are final one cycle after the last op (MAC register latency).
//  - Weight writes are honoured only in IDLE; ignored in ISSUE/FLUSH/DONE.
//    A write in the same IDLE cycle as an accept at the same index is visible
//    to that beat (write-first).
//  - Arithmetic: no products formed here; widths pass through unchanged.
//  - rst mid-window: abandon window, next cycle idle op, touched cleared; the
//    following window starts fresh with block=0 ops.
// STRUCTURE
//  - sparse_feeder_pkg: state enum {IDLE,ISSUE,FLUSH,DONE}, default widths,
//    NUM_SEL=4, idle-op constants, lowest-set-bit function.
//  - Sub-module weight_bank: 4 x DEPTH x DATA_WIDTH regfile, one sync-reset write
//    port, 4 parallel combinational read ports at a common index, write-first
//    bypass. Control FSM + output regs in this module.
// TESTING
//  1. Load W[0..3][3]={2,0,5,7}; send act 10 idx3 last=0 -> ops (s0,w2,blk0),
//     (s2,w5,blk0), (s3,w7,blk0) on t+1..t+3; Act_ready low 3 cycles.
//  2. Then act 4 idx3 last=1 -> (s0,w2,blk1),(s2,w5,blk1),(s3,w7,blk1), FLUSH
//     (s1,act0,blk0), then Window_done=1 one cycle; touched back to 0.
//  3. Act_value=0 last=0 -> accepted, no ops, Act_ready stays 1 next cycle.
//  4. Fresh window, single beat hitting all-zero weights with last=1 -> FLUSH
//     s0..s3 blk0 on 4 consecutive cycles, then Window_done.
//  5. Wt_wr_en during ISSUE -> weight unchanged on later read; write idx5=9 in
//     same IDLE cycle as accept of idx5 -> op uses weight 9.
//  6. rst for 1 cycle mid-ISSUE -> idle op, Act_ready=0 that cycle; next window's
//     first op per select has blk0; weights read back as 0.

Source files
------------

// File: rtl/sparse_feeder_pkg.sv
// Shared types, default widths and helpers for the sparse MAC operand feeder.
package sparse_feeder_pkg;

  localparam int unsigned DEF_DATA_WIDTH   = 8;
  localparam int unsigned DEF_IDX_WIDTH    = 4;
  localparam int unsigned DEF_SELECT_WIDTH = 2;
  localparam int unsigned NUM_SEL          = 4;
  localparam int unsigned SEL_IDX_W        = $clog2(NUM_SEL);

  typedef logic [NUM_SEL-1:0]   sel_mask_t;
  typedef logic [SEL_IDX_W-1:0] sel_idx_t;

  typedef enum logic [1:0] {IDLE, ISSUE, FLUSH, DONE} state_e;

  // Idle op: zero operands with block=1 adds nothing to the selected accumulator.
  localparam logic IDLE_BLOCK_CTRL = 1'b1;

  function automatic sel_idx_t lowest_set(input sel_mask_t m);
    sel_idx_t r;
    logic     found;
    r     = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < NUM_SEL; i++) begin
      if (m[i] && !found) begin
        r     = sel_idx_t'(i);
        found = 1'b1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/sparse_mac_feeder_weight_bank.sv
// Filter weight register file: one write port, NUM_SEL parallel reads at a shared
// channel index, with write-first bypass so a same-cycle write is seen by the read.
module weight_bank
  import sparse_feeder_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned IDX_WIDTH  = DEF_IDX_WIDTH
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                wr_en,
  input  sel_idx_t                            wr_sel,
  input  logic [IDX_WIDTH-1:0]                wr_addr,
  input  logic [DATA_WIDTH-1:0]               wr_data,
  input  logic [IDX_WIDTH-1:0]                rd_idx,
  output logic [NUM_SEL-1:0][DATA_WIDTH-1:0]  rd_data
);

  localparam int unsigned DEPTH = 2 ** IDX_WIDTH;

  logic [NUM_SEL-1:0][DEPTH-1:0][DATA_WIDTH-1:0] mem_q, mem_d;

  always_comb begin
    mem_d = mem_q;
    if (wr_en) mem_d[wr_sel][wr_addr] = wr_data;
  end

  always_comb begin
    rd_data = '0;
    for (int unsigned s = 0; s < NUM_SEL; s++) begin
      if (wr_en && (wr_addr == rd_idx) && (wr_sel == sel_idx_t'(s)))
        rd_data[s] = wr_data;
      else
        rd_data[s] = mem_q[s][rd_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) mem_q <= '0;
    else     mem_q <= mem_d;
  end

endmodule

// File: rtl/sparse_mac_feeder.sv
// Zero-skipping operand sequencer: turns a compressed activation stream into one
// MAC op per cycle, clearing each accumulator on first use and flushing unused ones.
module sparse_mac_feeder
  import sparse_feeder_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int unsigned IDX_WIDTH    = DEF_IDX_WIDTH,
  parameter int unsigned SELECT_WIDTH = DEF_SELECT_WIDTH
) (
  input  logic                    Clk,
  input  logic                    rst,
  input  logic                    Wt_wr_en,
  input  logic [SELECT_WIDTH-1:0] Wt_wr_sel,
  input  logic [IDX_WIDTH-1:0]    Wt_wr_addr,
  input  logic [DATA_WIDTH-1:0]   Wt_wr_data,
  input  logic                    Act_valid,
  output logic                    Act_ready,
  input  logic [DATA_WIDTH-1:0]   Act_value,
  input  logic [IDX_WIDTH-1:0]    Act_index,
  input  logic                    Act_last,
  output logic [DATA_WIDTH-1:0]   Mac_act,
  output logic [DATA_WIDTH-1:0]   Mac_weight,
  output logic [SELECT_WIDTH-1:0] Mac_select,
  output logic                    Mac_block_control,
  output logic                    Window_done
);

  state_e                  state_q, state_d;
  sel_mask_t               mask_q, mask_d;
  sel_mask_t               touched_q, touched_d;
  logic [DATA_WIDTH-1:0]   value_q, value_d;
  logic [IDX_WIDTH-1:0]    idx_q, idx_d;
  logic                    last_q, last_d;
  logic                    act_ready_q, act_ready_d;
  logic                    done_q, done_d;
  logic [DATA_WIDTH-1:0]   mac_act_q, mac_act_d;
  logic [DATA_WIDTH-1:0]   mac_weight_q, mac_weight_d;
  logic [SELECT_WIDTH-1:0] mac_sel_q, mac_sel_d;
  logic                    mac_blk_q, mac_blk_d;

  logic                              accept;
  logic                              wt_wr_en_gated;
  logic [IDX_WIDTH-1:0]              rd_idx;
  logic [NUM_SEL-1:0][DATA_WIDTH-1:0] rd_data;
  sel_mask_t                         nz_mask;

  logic                  issue_en, go_flush;
  sel_mask_t             issue_mask, issue_bit, flush_bit;
  logic [DATA_WIDTH-1:0] issue_act;
  sel_idx_t              issue_s, flush_s;

  assign accept         = Act_valid && act_ready_q;
  assign wt_wr_en_gated = Wt_wr_en && (state_q == IDLE);
  // Weights are frozen outside IDLE, so the latched index gives stable reads in ISSUE.
  assign rd_idx         = (state_q == IDLE) ? Act_index : idx_q;

  weight_bank #(
    .DATA_WIDTH (DATA_WIDTH),
    .IDX_WIDTH  (IDX_WIDTH)
  ) u_weight_bank (
    .clk     (Clk),
    .rst     (rst),
    .wr_en   (wt_wr_en_gated),
    .wr_sel  (sel_idx_t'(Wt_wr_sel)),
    .wr_addr (Wt_wr_addr),
    .wr_data (Wt_wr_data),
    .rd_idx  (rd_idx),
    .rd_data (rd_data)
  );

  always_comb begin
    nz_mask = '0;
    for (int unsigned s = 0; s < NUM_SEL; s++) nz_mask[s] = (rd_data[s] != '0);
  end

  // Registered outputs show the op chosen in the previous cycle, so each state
  // covers exactly the cycles its ops are visible on the MAC interface.
  always_comb begin
    state_d      = state_q;
    mask_d       = mask_q;
    touched_d    = touched_q;
    value_d      = value_q;
    idx_d        = idx_q;
    last_d       = last_q;
    done_d       = 1'b0;
    mac_act_d    = '0;
    mac_weight_d = '0;
    mac_sel_d    = mac_sel_q;
    mac_blk_d    = IDLE_BLOCK_CTRL;
    issue_en     = 1'b0;
    go_flush     = 1'b0;
    issue_mask   = mask_q;
    issue_act    = value_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          value_d = Act_value;
          idx_d   = Act_index;
          last_d  = Act_last;
          if ((Act_value != '0) && (nz_mask != '0)) begin
            issue_en   = 1'b1;
            issue_mask = nz_mask;
            issue_act  = Act_value;
          end else begin
            go_flush = Act_last;
          end
        end
      end
      ISSUE: begin
        if (mask_q != '0) issue_en = 1'b1;
        else if (last_q)  go_flush = 1'b1;
        else              state_d  = IDLE;
      end
      FLUSH: go_flush = 1'b1;
      DONE: begin
        touched_d = '0;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase

    issue_s   = lowest_set(issue_mask);
    issue_bit = sel_mask_t'(1) << issue_s;
    flush_s   = lowest_set(~touched_q);
    flush_bit = sel_mask_t'(1) << flush_s;

    if (issue_en) begin
      mac_act_d    = issue_act;
      mac_weight_d = rd_data[issue_s];
      mac_sel_d    = SELECT_WIDTH'(issue_s);
      mac_blk_d    = touched_q[issue_s];
      touched_d    = touched_q | issue_bit;
      mask_d       = issue_mask & ~issue_bit;
      state_d      = ISSUE;
    end else if (go_flush) begin
      if (&touched_q) begin
        done_d  = 1'b1;
        state_d = DONE;
      end else begin
        mac_sel_d = SELECT_WIDTH'(flush_s);
        mac_blk_d = 1'b0;
        touched_d = touched_q | flush_bit;
        state_d   = FLUSH;
      end
    end

    act_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge Clk) begin
    if (rst) begin
      state_q      <= IDLE;
      mask_q       <= '0;
      touched_q    <= '0;
      value_q      <= '0;
      idx_q        <= '0;
      last_q       <= 1'b0;
      act_ready_q  <= 1'b0;
      done_q       <= 1'b0;
      mac_act_q    <= '0;
      mac_weight_q <= '0;
      mac_sel_q    <= '0;
      mac_blk_q    <= IDLE_BLOCK_CTRL;
    end else begin
      state_q      <= state_d;
      mask_q       <= mask_d;
      touched_q    <= touched_d;
      value_q      <= value_d;
      idx_q        <= idx_d;
      last_q       <= last_d;
      act_ready_q  <= act_ready_d;
      done_q       <= done_d;
      mac_act_q    <= mac_act_d;
      mac_weight_q <= mac_weight_d;
      mac_sel_q    <= mac_sel_d;
      mac_blk_q    <= mac_blk_d;
    end
  end

  assign Act_ready         = act_ready_q;
  assign Window_done       = done_q;
  assign Mac_act           = mac_act_q;
  assign Mac_weight        = mac_weight_q;
  assign Mac_select        = mac_sel_q;
  assign Mac_block_control = mac_blk_q;

endmodule

// File: tb/tb_sparse_mac_feeder.sv
// Directed bench for sparse_mac_feeder: hand-computed op sequences per cycle.
module tb_sparse_mac_feeder;

  logic       Clk = 1'b0;
  logic       rst;
  logic       Wt_wr_en;
  logic [1:0] Wt_wr_sel;
  logic [3:0] Wt_wr_addr;
  logic [7:0] Wt_wr_data;
  logic       Act_valid;
  logic       Act_ready;
  logic [7:0] Act_value;
  logic [3:0] Act_index;
  logic       Act_last;
  logic [7:0] Mac_act;
  logic [7:0] Mac_weight;
  logic [1:0] Mac_select;
  logic       Mac_block_control;
  logic       Window_done;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  sparse_mac_feeder #(
    .DATA_WIDTH   (8),
    .IDX_WIDTH    (4),
    .SELECT_WIDTH (2)
  ) dut (
    .Clk               (Clk),
    .rst               (rst),
    .Wt_wr_en          (Wt_wr_en),
    .Wt_wr_sel         (Wt_wr_sel),
    .Wt_wr_addr        (Wt_wr_addr),
    .Wt_wr_data        (Wt_wr_data),
    .Act_valid         (Act_valid),
    .Act_ready         (Act_ready),
    .Act_value         (Act_value),
    .Act_index         (Act_index),
    .Act_last          (Act_last),
    .Mac_act           (Mac_act),
    .Mac_weight        (Mac_weight),
    .Mac_select        (Mac_select),
    .Mac_block_control (Mac_block_control),
    .Window_done       (Window_done)
  );

  always #5 Clk = ~Clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  // Checks the visible op {act,weight,select,block} and {ready,done}, then advances.
  task automatic expect_cycle(input string tag, input logic [7:0] act, input logic [7:0] wt,
                              input logic [1:0] sel, input logic blk,
                              input logic rdy, input logic dn);
    check_eq({tag, "/op"}, 32'({Mac_act, Mac_weight, Mac_select, Mac_block_control}),
             32'({act, wt, sel, blk}));
    check_eq({tag, "/hs"}, 32'({Act_ready, Window_done}), 32'({rdy, dn}));
    step();
  endtask

  task automatic write_wt(input logic [1:0] sel, input logic [3:0] addr, input logic [7:0] data);
    Wt_wr_en   = 1'b1;
    Wt_wr_sel  = sel;
    Wt_wr_addr = addr;
    Wt_wr_data = data;
    step();
    Wt_wr_en   = 1'b0;
  endtask

  task automatic send_beat(input logic [7:0] value, input logic [3:0] idx, input logic last);
    Act_valid = 1'b1;
    Act_value = value;
    Act_index = idx;
    Act_last  = last;
    step();
    Act_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; Wt_wr_en = 1'b0; Wt_wr_sel = '0; Wt_wr_addr = '0; Wt_wr_data = '0;
    Act_valid = 1'b0; Act_value = '0; Act_index = '0; Act_last = 1'b0;
    step();
    step();
    check_eq("reset/op", 32'({Mac_act, Mac_weight, Mac_select, Mac_block_control}), 32'h1);
    check_eq("reset/hs", 32'({Act_ready, Window_done}), 32'h0);
    rst = 1'b0;
    step();
    check_eq("ready_after_reset", 32'(Act_ready), 32'h1);

    // 1: three nonzero weights at idx 3, first use of each select clears it
    write_wt(2'd0, 4'd3, 8'd2);
    write_wt(2'd2, 4'd3, 8'd5);
    write_wt(2'd3, 4'd3, 8'd7);
    send_beat(8'd10, 4'd3, 1'b0);
    expect_cycle("t1_op0", 8'd10, 8'd2, 2'd0, 1'b0, 1'b0, 1'b0);
    expect_cycle("t1_op1", 8'd10, 8'd5, 2'd2, 1'b0, 1'b0, 1'b0);
    expect_cycle("t1_op2", 8'd10, 8'd7, 2'd3, 1'b0, 1'b0, 1'b0);
    expect_cycle("t1_idle", 8'd0, 8'd0, 2'd3, 1'b1, 1'b1, 1'b0);

    // 2: same selects now accumulate, select 1 flushed, then done pulse
    send_beat(8'd4, 4'd3, 1'b1);
    expect_cycle("t2_op0", 8'd4, 8'd2, 2'd0, 1'b1, 1'b0, 1'b0);
    expect_cycle("t2_op1", 8'd4, 8'd5, 2'd2, 1'b1, 1'b0, 1'b0);
    expect_cycle("t2_op2", 8'd4, 8'd7, 2'd3, 1'b1, 1'b0, 1'b0);
    expect_cycle("t2_flush1", 8'd0, 8'd0, 2'd1, 1'b0, 1'b0, 1'b0);
    expect_cycle("t2_done", 8'd0, 8'd0, 2'd1, 1'b1, 1'b0, 1'b1);
    expect_cycle("t2_idle", 8'd0, 8'd0, 2'd1, 1'b1, 1'b1, 1'b0);

    // 3: zero activation is consumed without ops
    send_beat(8'd0, 4'd3, 1'b0);
    expect_cycle("t3_zero_act", 8'd0, 8'd0, 2'd1, 1'b1, 1'b1, 1'b0);

    // 4: beat on all-zero weights ends window: four flushes then done
    send_beat(8'd6, 4'd7, 1'b1);
    expect_cycle("t4_flush0", 8'd0, 8'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    expect_cycle("t4_flush1", 8'd0, 8'd0, 2'd1, 1'b0, 1'b0, 1'b0);
    expect_cycle("t4_flush2", 8'd0, 8'd0, 2'd2, 1'b0, 1'b0, 1'b0);
    expect_cycle("t4_flush3", 8'd0, 8'd0, 2'd3, 1'b0, 1'b0, 1'b0);
    expect_cycle("t4_done", 8'd0, 8'd0, 2'd3, 1'b1, 1'b0, 1'b1);
    expect_cycle("t4_idle", 8'd0, 8'd0, 2'd3, 1'b1, 1'b1, 1'b0);

    // 5a: weight write during ISSUE must be dropped
    send_beat(8'd3, 4'd3, 1'b0);
    Wt_wr_en = 1'b1; Wt_wr_sel = 2'd0; Wt_wr_addr = 4'd3; Wt_wr_data = 8'd99;
    expect_cycle("t5_op0", 8'd3, 8'd2, 2'd0, 1'b0, 1'b0, 1'b0);
    expect_cycle("t5_op1", 8'd3, 8'd5, 2'd2, 1'b0, 1'b0, 1'b0);
    Wt_wr_en = 1'b0;
    expect_cycle("t5_op2", 8'd3, 8'd7, 2'd3, 1'b0, 1'b0, 1'b0);
    expect_cycle("t5_idle", 8'd0, 8'd0, 2'd3, 1'b1, 1'b1, 1'b0);
    send_beat(8'd1, 4'd3, 1'b1);
    expect_cycle("t5_keep_w0", 8'd1, 8'd2, 2'd0, 1'b1, 1'b0, 1'b0);
    expect_cycle("t5_keep_w2", 8'd1, 8'd5, 2'd2, 1'b1, 1'b0, 1'b0);
    expect_cycle("t5_keep_w3", 8'd1, 8'd7, 2'd3, 1'b1, 1'b0, 1'b0);
    expect_cycle("t5_flush1", 8'd0, 8'd0, 2'd1, 1'b0, 1'b0, 1'b0);
    expect_cycle("t5_done", 8'd0, 8'd0, 2'd1, 1'b1, 1'b0, 1'b1);
    expect_cycle("t5_idle2", 8'd0, 8'd0, 2'd1, 1'b1, 1'b1, 1'b0);

    // 5b: write-first bypass on the accept cycle
    Wt_wr_en = 1'b1; Wt_wr_sel = 2'd1; Wt_wr_addr = 4'd5; Wt_wr_data = 8'd9;
    send_beat(8'd8, 4'd5, 1'b1);
    Wt_wr_en = 1'b0;
    expect_cycle("t5_bypass", 8'd8, 8'd9, 2'd1, 1'b0, 1'b0, 1'b0);
    expect_cycle("t5b_flush0", 8'd0, 8'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    expect_cycle("t5b_flush2", 8'd0, 8'd0, 2'd2, 1'b0, 1'b0, 1'b0);
    expect_cycle("t5b_flush3", 8'd0, 8'd0, 2'd3, 1'b0, 1'b0, 1'b0);
    expect_cycle("t5b_done", 8'd0, 8'd0, 2'd3, 1'b1, 1'b0, 1'b1);
    expect_cycle("t5b_idle", 8'd0, 8'd0, 2'd3, 1'b1, 1'b1, 1'b0);

    // 6: reset mid-ISSUE abandons the window and clears weights
    send_beat(8'd5, 4'd3, 1'b0);
    rst = 1'b1;
    expect_cycle("t6_op0", 8'd5, 8'd2, 2'd0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    expect_cycle("t6_rst_idle", 8'd0, 8'd0, 2'd0, 1'b1, 1'b0, 1'b0);
    expect_cycle("t6_ready", 8'd0, 8'd0, 2'd0, 1'b1, 1'b1, 1'b0);
    send_beat(8'd5, 4'd3, 1'b1);
    expect_cycle("t6_flush0", 8'd0, 8'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    expect_cycle("t6_flush1", 8'd0, 8'd0, 2'd1, 1'b0, 1'b0, 1'b0);
    expect_cycle("t6_flush2", 8'd0, 8'd0, 2'd2, 1'b0, 1'b0, 1'b0);
    expect_cycle("t6_flush3", 8'd0, 8'd0, 2'd3, 1'b0, 1'b0, 1'b0);
    expect_cycle("t6_done", 8'd0, 8'd0, 2'd3, 1'b1, 1'b0, 1'b1);
    expect_cycle("t6_idle", 8'd0, 8'd0, 2'd3, 1'b1, 1'b1, 1'b0);
    write_wt(2'd2, 4'd3, 8'd4);
    send_beat(8'd2, 4'd3, 1'b1);
    expect_cycle("t6_fresh_op", 8'd2, 8'd4, 2'd2, 1'b0, 1'b0, 1'b0);
    expect_cycle("t6_fresh_f0", 8'd0, 8'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    expect_cycle("t6_fresh_f1", 8'd0, 8'd0, 2'd1, 1'b0, 1'b0, 1'b0);
    expect_cycle("t6_fresh_f3", 8'd0, 8'd0, 2'd3, 1'b0, 1'b0, 1'b0);
    expect_cycle("t6_fresh_done", 8'd0, 8'd0, 2'd3, 1'b1, 1'b0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
